// File: rtl/tuner_cmd_sequencer.sv
// tuner_cmd_sequencer
// Host-side initiator that walks a tuner controller through INIT -> SEARCH -> LOCK,
// bounds every command with a timeout, retries failed bring-ups and issues UNLOCK
// on abort. All outputs are registered: the combinational block computes the
// next value of every output and the state register captures it.

module tuner_cmd_sequencer #(
    parameter int TIMEOUT_WIDTH = 16,
    parameter int MAX_RETRY     = 3,
    parameter int RETRY_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles_i,
    output logic [4:0]               cmd_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    input  logic [4:0]               state_i,
    output logic                     busy_o,
    output logic                     locked_o,
    output logic                     error_o,
    output logic [1:0]               err_code_o,
    output logic [RETRY_WIDTH-1:0]   retry_cnt_o
);

    typedef enum logic [4:0] {
        CMD_INIT   = 5'd0,
        CMD_SEARCH = 5'd1,
        CMD_LOCK   = 5'd2,
        CMD_UNLOCK = 5'd3
    } tuner_cmd_e;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'd0,
        ST_ACTIVE = 5'd1,
        ST_DONE   = 5'd2,
        ST_ERROR  = 5'd3
    } tuner_state_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT,
        SEQ_LOCKED,
        SEQ_FAIL
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_TUNER   = 2'd2,
        ERR_RETRIES = 2'd3
    } err_code_e;

    localparam logic [RETRY_WIDTH-1:0]   RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRY);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX   = '1;

    seq_state_e                 state_q, state_d;
    tuner_cmd_e                 stage_q, stage_d;
    logic                       abort_pend_q, abort_pend_d;
    logic                       armed_q, armed_d;
    logic [TIMEOUT_WIDTH-1:0]   timer_q, timer_d;

    logic                       cmd_valid_d;
    logic                       busy_d;
    logic                       locked_d;
    logic                       error_d;
    logic [1:0]                 err_code_d;
    logic [RETRY_WIDTH-1:0]     retry_d;

    logic                       xfer;
    logic                       fail;
    logic [1:0]                 fail_code;
    logic                       done_seen;
    logic                       err_seen;
    logic                       timed_out;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        stage_d      = stage_q;
        abort_pend_d = abort_pend_q;
        armed_d      = armed_q;
        timer_d      = timer_q;
        locked_d     = locked_o;
        error_d      = error_o;
        err_code_d   = err_code_o;
        retry_d      = retry_cnt_o;
        fail         = 1'b0;
        fail_code    = ERR_NONE;

        xfer      = cmd_valid_o && cmd_ready_i;
        // DONE/ERROR only count once ACTIVE has been seen for this command, so a
        // DONE left over from the previous command cannot advance the sequence.
        done_seen = armed_q && (state_i == ST_DONE);
        err_seen  = armed_q && (state_i == ST_ERROR);
        timed_out = (timeout_cycles_i != '0) && (timer_q == timeout_cycles_i);

        case (state_q)
            SEQ_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d      = SEQ_ISSUE;
                    stage_d      = CMD_INIT;
                    retry_d      = '0;
                    err_code_d   = ERR_NONE;
                    abort_pend_d = 1'b0;
                end
            end

            SEQ_ISSUE: begin
                if (abort_i && stage_q != CMD_UNLOCK) begin
                    abort_pend_d = 1'b1;
                end
                if (xfer) begin
                    // A pending abort replaces the WAIT phase with an UNLOCK.
                    if ((abort_pend_q || abort_i) && stage_q != CMD_UNLOCK) begin
                        stage_d      = CMD_UNLOCK;
                        abort_pend_d = 1'b0;
                    end else begin
                        state_d = SEQ_WAIT;
                        timer_d = '0;
                        armed_d = 1'b0;
                    end
                end
            end

            SEQ_WAIT: begin
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TIMEOUT_WIDTH'(1);
                end
                if (state_i == ST_ACTIVE) begin
                    armed_d = 1'b1;
                end
                if (abort_i && stage_q != CMD_UNLOCK) begin
                    state_d = SEQ_ISSUE;
                    stage_d = CMD_UNLOCK;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else if (err_seen) begin
                    fail      = 1'b1;
                    fail_code = ERR_TUNER;
                end else if (done_seen) begin
                    case (stage_q)
                        CMD_INIT: begin
                            state_d = SEQ_ISSUE;
                            stage_d = CMD_SEARCH;
                        end
                        CMD_SEARCH: begin
                            state_d = SEQ_ISSUE;
                            stage_d = CMD_LOCK;
                        end
                        CMD_LOCK: begin
                            state_d  = SEQ_LOCKED;
                            locked_d = 1'b1;
                        end
                        default: begin
                            state_d = SEQ_IDLE;
                        end
                    endcase
                end
            end

            SEQ_LOCKED: begin
                if (abort_i) begin
                    state_d  = SEQ_ISSUE;
                    stage_d  = CMD_UNLOCK;
                    locked_d = 1'b0;
                end else if (state_i == ST_ERROR) begin
                    locked_d  = 1'b0;
                    fail      = 1'b1;
                    fail_code = ERR_TUNER;
                end
            end

            SEQ_FAIL: begin
                if (abort_i) begin
                    state_d      = SEQ_ISSUE;
                    stage_d      = CMD_UNLOCK;
                    error_d      = 1'b0;
                    abort_pend_d = 1'b0;
                end else if (start_i) begin
                    state_d      = SEQ_ISSUE;
                    stage_d      = CMD_INIT;
                    retry_d      = '0;
                    err_code_d   = ERR_NONE;
                    error_d      = 1'b0;
                    abort_pend_d = 1'b0;
                end
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        // Shared failure handling: UNLOCK never retries, otherwise restart at
        // INIT until the retry budget is spent.
        if (fail) begin
            if (stage_q == CMD_UNLOCK) begin
                state_d    = SEQ_IDLE;
                err_code_d = fail_code;
            end else if (retry_cnt_o < RETRY_LIMIT) begin
                retry_d    = retry_cnt_o + RETRY_WIDTH'(1);
                state_d    = SEQ_ISSUE;
                stage_d    = CMD_INIT;
                err_code_d = fail_code;
            end else begin
                state_d    = SEQ_FAIL;
                error_d    = 1'b1;
                err_code_d = ERR_RETRIES;
            end
        end

        // Valid drops for one cycle after every transfer, even when the next
        // command (an abort-driven UNLOCK) follows straight on.
        cmd_valid_d = (state_d == SEQ_ISSUE) && !xfer;
        busy_d      = (state_d == SEQ_ISSUE) || (state_d == SEQ_WAIT);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEQ_IDLE;
            stage_q      <= CMD_INIT;
            abort_pend_q <= 1'b0;
            armed_q      <= 1'b0;
            timer_q      <= '0;
            cmd_o        <= CMD_INIT;
            cmd_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            locked_o     <= 1'b0;
            error_o      <= 1'b0;
            err_code_o   <= ERR_NONE;
            retry_cnt_o  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            stage_q      <= stage_d;
            abort_pend_q <= abort_pend_d;
            armed_q      <= armed_d;
            timer_q      <= timer_d;
            cmd_o        <= stage_d;
            cmd_valid_o  <= cmd_valid_d;
            busy_o       <= busy_d;
            locked_o     <= locked_d;
            error_o      <= error_d;
            err_code_o   <= err_code_d;
            retry_cnt_o  <= retry_d;
        end
    end

endmodule

// File: tb/tb_tuner_cmd_sequencer.sv
// tb_tuner_cmd_sequencer
// Directed bench. Stimulus pushes the expected {command, retry count} of every
// transfer into a queue; a monitor on the falling edge pops and compares on each
// valid/ready handshake. Status outputs are checked directly with check().

module tb_tuner_cmd_sequencer;

    localparam logic [4:0] C_INIT   = 5'd0;
    localparam logic [4:0] C_SEARCH = 5'd1;
    localparam logic [4:0] C_LOCK   = 5'd2;
    localparam logic [4:0] C_UNLOCK = 5'd3;

    localparam logic [4:0] S_IDLE   = 5'd0;
    localparam logic [4:0] S_ACTIVE = 5'd1;
    localparam logic [4:0] S_DONE   = 5'd2;
    localparam logic [4:0] S_ERROR  = 5'd3;

    typedef struct packed {
        logic [4:0] cmd;
        logic [1:0] retry;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [15:0] timeout_cycles_i;
    logic [4:0]  cmd_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [4:0]  state_i;
    logic        busy_o;
    logic        locked_o;
    logic        error_o;
    logic [1:0]  err_code_o;
    logic [1:0]  retry_cnt_o;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    tuner_cmd_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .timeout_cycles_i (timeout_cycles_i),
        .cmd_o            (cmd_o),
        .cmd_valid_o      (cmd_valid_o),
        .cmd_ready_i      (cmd_ready_i),
        .state_i          (state_i),
        .busy_o           (busy_o),
        .locked_o         (locked_o),
        .error_o          (error_o),
        .err_code_o       (err_code_o),
        .retry_cnt_o      (retry_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_cmd(input logic [4:0] c, input logic [1:0] r);
        exp_t e;
        e.cmd   = c;
        e.retry = r;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a handshake and returns just after the transfer edge.
    task automatic wait_xfer(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_valid_o && cmd_ready_i) begin
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no transfer within 100 cycles, required one", name);
        end
    endtask

    // Tuner answers the command just accepted: ACTIVE for 2 cycles, then DONE.
    task automatic respond();
        state_i = S_ACTIVE;
        tick();
        tick();
        state_i = S_DONE;
        tick();
        state_i = S_IDLE;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    // Scoreboard monitor: one pop per handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && cmd_valid_o && cmd_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_xfer: got cmd %0d retry %0d, required no transfer",
                         cmd_o, retry_cnt_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (cmd_o !== mon_e.cmd || retry_cnt_o !== mon_e.retry) begin
                    miscompares++;
                    $display("FAIL xfer: got cmd %0d retry %0d, expected cmd %0d retry %0d",
                             cmd_o, retry_cnt_o, mon_e.cmd, mon_e.retry);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n            = 1'b0;
        start_i          = 1'b0;
        abort_i          = 1'b0;
        timeout_cycles_i = 16'd0;
        cmd_ready_i      = 1'b1;
        state_i          = S_IDLE;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset values
        check("rst_valid",    32'(cmd_valid_o), 32'd0);
        check("rst_cmd",      32'(cmd_o),       32'(C_INIT));
        check("rst_busy",     32'(busy_o),      32'd0);
        check("rst_locked",   32'(locked_o),    32'd0);
        check("rst_error",    32'(error_o),     32'd0);
        check("rst_err_code", 32'(err_code_o),  32'd0);
        check("rst_retry",    32'(retry_cnt_o), 32'd0);

        // Nominal bring-up
        expect_cmd(C_INIT, 2'd0);
        expect_cmd(C_SEARCH, 2'd0);
        expect_cmd(C_LOCK, 2'd0);
        pulse_start();
        check("nom_latency_valid", 32'(cmd_valid_o), 32'd1);
        check("nom_latency_cmd",   32'(cmd_o),       32'(C_INIT));
        wait_xfer("nom_init");
        respond();
        wait_xfer("nom_search");
        respond();
        wait_xfer("nom_lock");
        respond();
        check("nom_locked", 32'(locked_o),    32'd1);
        check("nom_busy",   32'(busy_o),      32'd0);
        check("nom_retry",  32'(retry_cnt_o), 32'd0);

        // Abort from LOCKED, then backpressure on SEARCH
        expect_cmd(C_UNLOCK, 2'd0);
        pulse_abort();
        check("abort_locked_clr", 32'(locked_o), 32'd0);
        wait_xfer("bp_unlock");
        respond();
        check("bp_idle_busy", 32'(busy_o), 32'd0);
        expect_cmd(C_INIT, 2'd0);
        expect_cmd(C_SEARCH, 2'd0);
        expect_cmd(C_LOCK, 2'd0);
        pulse_start();
        wait_xfer("bp_init");
        cmd_ready_i = 1'b0;
        respond();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", 32'(cmd_valid_o), 32'd1);
            check("bp_cmd_hold",   32'(cmd_o),       32'(C_SEARCH));
            tick();
        end
        cmd_ready_i = 1'b1;
        wait_xfer("bp_search");
        check("bp_valid_drop", 32'(cmd_valid_o), 32'd0);
        respond();
        wait_xfer("bp_lock");
        respond();
        check("bp_locked", 32'(locked_o), 32'd1);

        // Stale DONE across the INIT transfer
        expect_cmd(C_UNLOCK, 2'd0);
        pulse_abort();
        wait_xfer("stale_unlock");
        respond();
        expect_cmd(C_INIT, 2'd0);
        expect_cmd(C_SEARCH, 2'd0);
        expect_cmd(C_LOCK, 2'd0);
        pulse_start();
        state_i = S_DONE;
        wait_xfer("stale_init");
        repeat (5) tick();
        check("stale_no_advance", 32'(cmd_valid_o), 32'd0);
        check("stale_busy",       32'(busy_o),      32'd1);
        respond();
        wait_xfer("stale_search");
        respond();
        wait_xfer("stale_lock");
        respond();
        check("stale_locked", 32'(locked_o), 32'd1);

        // Loss of lock
        expect_cmd(C_INIT, 2'd1);
        state_i = S_ERROR;
        tick();
        state_i = S_IDLE;
        check("lol_locked",   32'(locked_o),    32'd0);
        check("lol_retry",    32'(retry_cnt_o), 32'd1);
        check("lol_err_code", 32'(err_code_o),  32'd2);
        check("lol_valid",    32'(cmd_valid_o), 32'd1);
        check("lol_cmd",      32'(cmd_o),       32'(C_INIT));
        expect_cmd(C_SEARCH, 2'd1);
        expect_cmd(C_LOCK, 2'd1);
        wait_xfer("lol_init");
        respond();
        wait_xfer("lol_search");
        respond();
        wait_xfer("lol_lock");
        respond();
        check("lol_relocked", 32'(locked_o), 32'd1);
        expect_cmd(C_UNLOCK, 2'd1);
        pulse_abort();
        wait_xfer("lol_unlock");
        respond();
        check("lol_idle_busy",  32'(busy_o),      32'd0);
        check("lol_idle_retry", 32'(retry_cnt_o), 32'd1);

        // Timeout and retry exhaustion: timer reads 0 on the first WAIT cycle,
        // so the compare against 10 fires on the 11th WAIT cycle.
        timeout_cycles_i = 16'd10;
        expect_cmd(C_INIT, 2'd0);
        expect_cmd(C_INIT, 2'd1);
        expect_cmd(C_INIT, 2'd2);
        expect_cmd(C_INIT, 2'd3);
        pulse_start();
        check("to_start_retry", 32'(retry_cnt_o), 32'd0);
        state_i = S_ACTIVE;
        for (int r = 1; r <= 3; r++) begin
            wait_xfer("to_init");
            n = 0;
            while (!cmd_valid_o && n < 50) begin
                tick();
                n++;
            end
            check("to_wait_cycles", 32'(n),           32'd11);
            check("to_retry",       32'(retry_cnt_o), 32'(r));
            check("to_err_code",    32'(err_code_o),  32'd1);
        end
        wait_xfer("to_init_last");
        repeat (11) tick();
        check("to_error",    32'(error_o),     32'd1);
        check("to_err_code", 32'(err_code_o),  32'd3);
        check("to_retry",    32'(retry_cnt_o), 32'd3);
        check("to_busy",     32'(busy_o),      32'd0);
        check("to_valid",    32'(cmd_valid_o), 32'd0);

        // Abort from FAIL
        state_i = S_IDLE;
        expect_cmd(C_UNLOCK, 2'd3);
        pulse_abort();
        check("fail_abort_error", 32'(error_o),     32'd0);
        check("fail_abort_valid", 32'(cmd_valid_o), 32'd1);
        wait_xfer("fail_unlock");
        respond();
        check("fail_idle_busy", 32'(busy_o), 32'd0);
        timeout_cycles_i = 16'd0;

        // start and abort together in IDLE: nothing issued
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (3) tick();
        check("sa_valid", 32'(cmd_valid_o), 32'd0);
        check("sa_busy",  32'(busy_o),      32'd0);

        // Abort during SEARCH handshake with ready low
        expect_cmd(C_INIT, 2'd0);
        pulse_start();
        wait_xfer("ab_init");
        cmd_ready_i = 1'b0;
        respond();
        pulse_abort();
        tick();
        check("ab_valid_hold", 32'(cmd_valid_o), 32'd1);
        check("ab_cmd_hold",   32'(cmd_o),       32'(C_SEARCH));
        expect_cmd(C_SEARCH, 2'd0);
        expect_cmd(C_UNLOCK, 2'd0);
        cmd_ready_i = 1'b1;
        wait_xfer("ab_search");
        check("ab_valid_gap", 32'(cmd_valid_o), 32'd0);
        wait_xfer("ab_unlock");
        respond();
        check("ab_locked", 32'(locked_o),    32'd0);
        check("ab_busy",   32'(busy_o),      32'd0);
        check("ab_valid",  32'(cmd_valid_o), 32'd0);

        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
